// File: rtl/cofactor_sequencer_pkg.sv
// Shared types and constants for the cofactor literal sequencer:
// FSM states, op codes and datapath mux selects.
package cofactor_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SCAN  = 3'd3,
    TOFF  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'd0;
  localparam logic [1:0] OP_COFACTOR = 2'd1;
  localparam logic [1:0] OP_TOFFOLI  = 2'd2;
  localparam logic [1:0] OP_NOP      = 2'd3;

  localparam logic [2:0] MUX_REMAIN = 3'd0;
  localparam logic [2:0] MUX_BASIS  = 3'd1;
  localparam logic [2:0] MUX_MULT   = 3'd2;
  localparam logic [2:0] MUX_EXT    = 3'd3;
  localparam logic [2:0] MUX_TOFF   = 3'd4;

endpackage

// File: rtl/cofactor_sequencer.sv
// Control FSM for the cofactor literal datapath: sequences row loads, cofactor
// elimination passes and Toffoli phase passes over the circular row array.
module cofactor_sequencer
  import cofactor_sequencer_pkg::*;
#(
  parameter int num_qubit = 3,
  localparam int CNT_W = $clog2(num_qubit + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             ext_valid,
  output logic             ext_ready,
  input  logic             anticommute,
  input  logic             flag_anticommute,
  output logic [2:0]       mux_shift_in,
  output logic             rst_flag,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] first_row_idx,
  output logic             random_outcome
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             last_row;
  logic             capture_first;

  assign last_row = (cnt == CNT_W'(num_qubit - 1));

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    mux_shift_in  = MUX_REMAIN;
    shift_en      = 1'b0;
    ext_ready     = 1'b0;
    done          = 1'b0;
    capture_first = 1'b0;
    busy          = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD:     state_next = LOAD;
            OP_COFACTOR: state_next = CLEAR;
            OP_TOFFOLI:  state_next = TOFF;
            default:     state_next = DONE;
          endcase
        end
      end

      CLEAR: state_next = SCAN;

      SCAN: begin
        shift_en = 1'b1;
        // The first anticommuting row becomes the basis row; later ones get multiplied by it.
        if (anticommute && !flag_anticommute) begin
          mux_shift_in  = MUX_BASIS;
          capture_first = 1'b1;
        end else if (anticommute) begin
          mux_shift_in = MUX_MULT;
        end
        if (last_row) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      LOAD: begin
        ext_ready    = 1'b1;
        mux_shift_in = MUX_EXT;
        shift_en     = ext_valid;
        if (ext_valid) begin
          if (last_row) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      TOFF: begin
        mux_shift_in = MUX_TOFF;
        shift_en     = 1'b1;
        if (last_row) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        done       = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // rst_flag is an async clear in the datapath, so it must come straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rst_flag       <= 1'b0;
      first_row_idx  <= '0;
      random_outcome <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rst_flag <= (state_next == CLEAR);
      if (state == CLEAR) begin
        first_row_idx  <= '0;
        random_outcome <= 1'b0;
      end else if (capture_first) begin
        first_row_idx  <= cnt;
        random_outcome <= 1'b1;
      end
    end
  end

endmodule
